// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder: packs field-level requests into R/I/J
// machine words and writes them to instruction memory at consecutive word
// addresses starting from a base sampled on start.
module instr_encoder #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_addr,
    output logic [DWIDTH-1:0] out_instr,
    output logic              done,
    output logic [AWIDTH:0]   word_count,
    output logic              err_illegal,
    output logic              err_wrap
);

    // Mnemonic select codes
    localparam logic [3:0] KAdd  = 4'd0;
    localparam logic [3:0] KSub  = 4'd1;
    localparam logic [3:0] KAnd  = 4'd2;
    localparam logic [3:0] KOr   = 4'd3;
    localparam logic [3:0] KNor  = 4'd4;
    localparam logic [3:0] KSlt  = 4'd5;
    localparam logic [3:0] KJr   = 4'd6;
    localparam logic [3:0] KAddi = 4'd7;
    localparam logic [3:0] KSlti = 4'd8;
    localparam logic [3:0] KLw   = 4'd9;
    localparam logic [3:0] KSw   = 4'd10;
    localparam logic [3:0] KBeq  = 4'd11;
    localparam logic [3:0] KJ    = 4'd12;
    localparam logic [3:0] KJal  = 4'd13;

    // Primary opcodes
    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpAddi    = 6'b001000;
    localparam logic [5:0] OpSlti    = 6'b001010;
    localparam logic [5:0] OpLw      = 6'b100011;
    localparam logic [5:0] OpSw      = 6'b101011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnNor = 6'b100111;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnJr  = 6'b001000;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]   out_instr_q, out_instr_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [AWIDTH:0]     word_count_q, word_count_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_wrap_q, err_wrap_d;

    logic                accept;
    logic                fire;
    logic                enc_legal;
    logic [DWIDTH-1:0]   enc_word;

    // The output register may take a new word when it is empty or being drained
    assign in_ready = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready;

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    // The counter always points at the word currently held (or the next one)
    assign out_addr    = addr_q;
    assign word_count  = word_count_q;
    assign err_illegal = err_illegal_q;
    assign err_wrap    = err_wrap_q;
    assign done        = (state_q == StDone);

    // Field packing for the selected mnemonic; unused fields stay zero
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (kind)
            KAdd:    enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnAdd};
            KSub:    enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnSub};
            KAnd:    enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnAnd};
            KOr:     enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnOr};
            KNor:    enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnNor};
            KSlt:    enc_word = {OpSpecial, rs, rt, rd, 5'd0, FnSlt};
            KJr:     enc_word = {OpSpecial, rs, 5'd0, 5'd0, 5'd0, FnJr};
            KAddi:   enc_word = {OpAddi, rs, rt, imm};
            KSlti:   enc_word = {OpSlti, rs, rt, imm};
            KLw:     enc_word = {OpLw, rs, rt, imm};
            KSw:     enc_word = {OpSw, rs, rt, imm};
            KBeq:    enc_word = {OpBeq, rs, rt, imm};
            KJ:      enc_word = {OpJ, target};
            KJal:    enc_word = {OpJal, target};
            default: enc_legal = 1'b0;
        endcase
    end

    // Load sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (accept && in_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register, address/word counters and sticky error flags
    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        addr_d        = addr_q;
        word_count_d  = word_count_q;
        err_illegal_d = err_illegal_q;
        err_wrap_d    = err_wrap_q;

        if (state_q == StIdle && start) begin
            addr_d        = base_addr;
            word_count_d  = '0;
            err_illegal_d = 1'b0;
            err_wrap_d    = 1'b0;
        end

        if (fire) begin
            out_valid_d  = 1'b0;
            addr_d       = addr_q + AWIDTH'(1);
            word_count_d = word_count_q + (AWIDTH + 1)'(1);
            if (addr_q == '1) begin
                err_wrap_d = 1'b1;
            end
        end

        // An illegal request is consumed without producing a word
        if (accept) begin
            if (enc_legal) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_word;
            end else begin
                err_illegal_d = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset clears any pending word immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            addr_q        <= '0;
            word_count_q  <= '0;
            err_illegal_q <= 1'b0;
            err_wrap_q    <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            addr_q        <= addr_d;
            word_count_q  <= word_count_d;
            err_illegal_q <= err_illegal_d;
            err_wrap_q    <= err_wrap_d;
        end
    end

endmodule
